// File: rtl/vid_fetch.sv
// vid_fetch: video RAM line fetcher with one-byte prefetch and 1bpp/2bpp serialiser.
// Optional VID_FETCH_LINE_DOUBLE_EN shows each RAM line on two output lines.
module vid_fetch #(
    parameter int LINES          = 192,
    parameter int BYTES_PER_LINE = 32,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_W         = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              mode,
    output logic [ADDR_W-1:0] vid_addr,
    input  logic [7:0]        vid_dout,
    output logic              pix_valid,
    output logic [1:0]        pix_data,
    output logic              line_busy,
    output logic              underrun
);

    localparam int LW = $clog2(LINES + 1);
    localparam int BW = $clog2(BYTES_PER_LINE);
    localparam logic [BW-1:0] LAST_B = BW'(BYTES_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, PRIME, LOAD, ACTIVE} state_t;

    state_t          state, state_nx;
    logic [LW-1:0]   line, line_eff;
    logic [7:0]      cur, hold, src, sh;
    logic            hold_vld;
    logic [3:0]      cnt;
    logic [2:0]      sidx;
    logic [BW-1:0]   ld_idx, rq_idx;
    logic            rq_first, rq_d0, rq_d1;
    logic            mode_q;
    logic            accept, last;
    logic [1:0]      px;
`ifdef VID_FETCH_LINE_DOUBLE_EN
    logic            parity;
`endif

    function automatic logic [ADDR_W-1:0] addr_of(input logic [LW-1:0] l,
                                                  input logic [BW-1:0] b);
        return ADDR_W'(BASE_ADDR + int'(l) * BYTES_PER_LINE + int'(b));
    endfunction

    // An empty shifter serves its first pixel straight from the hold register.
    always_comb begin
        line_eff = frame_start ? '0 : line;
        accept   = (state == IDLE) && line_start && (int'(line_eff) < LINES);
        src      = (cnt == 4'd0) ? hold : cur;
        sidx     = (cnt == 4'd0) ? 3'd0 : 3'(4'd8 - cnt);
        sh       = src << (mode_q ? (sidx & 3'b110) : sidx);
        px       = mode_q ? sh[7:6] : {1'b0, sh[7]};
        last     = (state == ACTIVE) && pix_ce && (cnt == 4'd1) && (ld_idx == LAST_B);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = PRIME;
            PRIME:   state_nx = LOAD;
            LOAD:    state_nx = ACTIVE;
            ACTIVE:  if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_addr  <= ADDR_W'(BASE_ADDR);
            pix_valid <= 1'b0;
            pix_data  <= 2'd0;
            line_busy <= 1'b0;
            underrun  <= 1'b0;
            line      <= '0;
            cur       <= 8'd0;
            hold      <= 8'd0;
            hold_vld  <= 1'b0;
            cnt       <= 4'd0;
            ld_idx    <= '0;
            rq_idx    <= '0;
            rq_first  <= 1'b0;
            rq_d0     <= 1'b0;
            rq_d1     <= 1'b0;
            mode_q    <= 1'b0;
`ifdef VID_FETCH_LINE_DOUBLE_EN
            parity    <= 1'b0;
`endif
        end else begin
            rq_d0 <= 1'b0;
            rq_d1 <= rq_d0;
            if (rq_d1) begin
                hold     <= vid_dout;
                hold_vld <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pix_ce) begin
                        pix_valid <= 1'b0;
                        pix_data  <= 2'd0;
                    end
                    if (accept) begin
                        vid_addr  <= addr_of(line_eff, '0);
                        mode_q    <= mode;
                        line_busy <= 1'b1;
                        rq_idx    <= '0;
                        ld_idx    <= '0;
                        hold_vld  <= 1'b0;
                        cnt       <= 4'd0;
                        rq_first  <= 1'b0;
                    end
                end
                PRIME: begin
                    if (pix_ce) pix_valid <= 1'b0;
                end
                LOAD: begin
                    cur      <= vid_dout;
                    cnt      <= 4'd8;
                    rq_first <= 1'b1;
                    if (pix_ce) pix_valid <= 1'b0;
                end
                ACTIVE: begin
                    if (rq_first) begin
                        rq_first <= 1'b0;
                        rq_idx   <= BW'(1);
                        vid_addr <= addr_of(line, BW'(1));
                        rq_d0    <= 1'b1;
                    end
                    if (pix_ce) begin
                        if (cnt != 4'd0) begin
                            pix_valid <= 1'b1;
                            pix_data  <= px;
                            cnt       <= cnt - 4'd1;
                        end else if (hold_vld) begin
                            pix_valid <= 1'b1;
                            pix_data  <= px;
                            cur       <= hold;
                            cnt       <= 4'd7;
                            hold_vld  <= 1'b0;
                            ld_idx    <= ld_idx + 1'b1;
                            if (rq_idx != LAST_B) begin
                                rq_idx   <= rq_idx + 1'b1;
                                vid_addr <= addr_of(line, rq_idx + 1'b1);
                                rq_d0    <= 1'b1;
                            end
                        end else begin
                            underrun  <= 1'b1;
                            pix_valid <= 1'b0;
                            pix_data  <= 2'd0;
                        end
                    end
                    if (last) begin
                        line_busy <= 1'b0;
`ifdef VID_FETCH_LINE_DOUBLE_EN
                        parity <= ~parity;
                        if (parity) line <= line + 1'b1;
`else
                        line <= line + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
            // Frame restart wins over the end-of-line advance.
            if (frame_start) begin
                line     <= '0;
                underrun <= 1'b0;
`ifdef VID_FETCH_LINE_DOUBLE_EN
                parity   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vid_fetch.sv
// tb_vid_fetch: directed bench for vid_fetch with a registered-read RAM model.
// Expected addresses and pixels are derived from the bench's own memory image.
module tb_vid_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        mode = 1'b0;
    logic [12:0] vid_addr;
    logic [7:0]  vid_dout = 8'h00;
    logic        pix_valid;
    logic [1:0]  pix_data;
    logic        line_busy;
    logic        underrun;

    logic [7:0]  mem [6144];
    logic [1:0]  pxq [$];
    logic [12:0] addrq [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_lines = 0;
    int          first_lat;
    int          exp_base;
    bit          exp_acc;
    bit          tmo;

    vid_fetch dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
        .frame_start(frame_start), .line_start(line_start), .mode(mode),
        .vid_addr(vid_addr), .vid_dout(vid_dout), .pix_valid(pix_valid),
        .pix_data(pix_data), .line_busy(line_busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        vid_dout <= (vid_addr < 13'd6144) ? mem[vid_addr] : 8'h00;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ram_line();
`ifdef VID_FETCH_LINE_DOUBLE_EN
        return done_lines / 2;
`else
        return done_lines;
`endif
    endfunction

    function automatic logic [1:0] exp_px(input bit md, input logic [7:0] b, input int k8);
        if (md) return 2'((b >> (6 - 2 * (k8 / 2))) & 8'h03);
        return 2'((b >> (7 - k8)) & 8'h01);
    endfunction

    function automatic int line_errs(input bit md);
        int e = 0;
        if (addrq.size() != 32) e += 100;
        else for (int i = 0; i < 32; i++) if (addrq[i] != 13'(exp_base + i)) e++;
        if (pxq.size() != 256) e += 1000;
        else for (int k = 0; k < 256; k++)
            if (pxq[k] !== exp_px(md, mem[exp_base + k / 8], k % 8)) e++;
        return e;
    endfunction

    // One line_start; mode input is flipped mid-line and an extra
    // line_start may be pulsed at cycle pulse_at while the line is busy.
    task automatic run_line(input bit md, input int period, input bit fs, input int pulse_at);
        pxq.delete();
        addrq.delete();
        tmo = 0;
        first_lat = -1;
        if (fs) done_lines = 0;
        exp_acc  = (ram_line() < 192);
        exp_base = ram_line() * 32;
        frame_start = fs;
        line_start  = 1'b1;
        mode        = md;
        pix_ce      = (period == 1);
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        addrq.push_back(vid_addr);
        chk("accept", line_busy, exp_acc);
        for (int c = 1; line_busy; c++) begin
            if (c > 3000) begin
                tmo = 1;
                break;
            end
            pix_ce     = (c % period == 0);
            line_start = (c == pulse_at);
            mode       = (c > 20) ? ~md : md;
            tick();
            if (pix_ce && pix_valid) begin
                if (first_lat < 0) first_lat = c;
                pxq.push_back(pix_data);
            end
            if (vid_addr != addrq[$]) addrq.push_back(vid_addr);
        end
        pix_ce     = 1'b0;
        line_start = 1'b0;
        mode       = md;
        if (exp_acc) done_lines++;
    endtask

    initial begin
        logic [1:0] pat [8];
        int e;
        int cnt;
        for (int i = 0; i < 6144; i++) mem[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 32; i++) mem[i] = 8'h80;
        mem[32] = 8'hE4;

        repeat (3) tick();
        chk("rst_addr", vid_addr, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_busy", line_busy, 0);
        chk("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        tick();

        // 1bpp, pix_ce every clk, line 0 of 0x80 bytes
        run_line(1'b0, 1, 1'b1, -1);
        chk("l0_timeout", tmo, 0);
        chk("l0_latency", first_lat, 3);
        chk("l0_count", pxq.size(), 256);
        e = 0;
        for (int k = 0; k < pxq.size(); k++) if (pxq[k] !== ((k % 8 == 0) ? 2'd1 : 2'd0)) e++;
        chk("l0_pattern", e, 0);
        chk("l0_line", line_errs(1'b0), 0);
        chk("l0_underrun", underrun, 0);
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        chk("l0_valid_drop", pix_valid, 0);

        // 2bpp, pix_ce every 2nd clk, second line
        run_line(1'b1, 2, 1'b0, -1);
        chk("l1_timeout", tmo, 0);
        chk("l1_first_addr", addrq[0], exp_base);
        chk("l1_latency", first_lat, 4);
        chk("l1_line", line_errs(1'b1), 0);
`ifndef VID_FETCH_LINE_DOUBLE_EN
        pat = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
        e = 0;
        for (int k = 0; k < 8; k++) if (k >= pxq.size() || pxq[k] !== pat[k]) e++;
        chk("l1_e4_pairs", e, 0);
        chk("l1_addr32", addrq[0], 32);
`endif

        // line_start while busy must not restart the line
        run_line(1'b0, 1, 1'b0, 50);
        chk("busy_timeout", tmo, 0);
        chk("busy_no_restart", line_errs(1'b0), 0);

`ifdef VID_FETCH_LINE_DOUBLE_EN
        run_line(1'b0, 1, 1'b1, -1);
        chk("dbl_a", addrq[0], 0);
        chk("dbl_a_line", line_errs(1'b0), 0);
        run_line(1'b0, 1, 1'b0, -1);
        chk("dbl_b", addrq[0], 0);
        chk("dbl_b_line", line_errs(1'b0), 0);
        run_line(1'b0, 1, 1'b0, -1);
        chk("dbl_c", addrq[0], 32);
        chk("dbl_c_line", line_errs(1'b0), 0);
`else
        e = 0;
        while (done_lines < 191) begin
            run_line(1'b0, 1, 1'b0, -1);
            e += line_errs(1'b0) + int'(tmo);
        end
        chk("bulk_lines", e, 0);
        run_line(1'b1, 1, 1'b0, -1);
        chk("last_first", addrq[0], 6112);
        chk("last_final", addrq[$], 6143);
        chk("last_line", line_errs(1'b1), 0);
        run_line(1'b0, 1, 1'b0, -1);
        e = 0;
        pix_ce = 1'b1;
        repeat (10) begin
            tick();
            if (pix_valid !== 1'b0) e++;
        end
        pix_ce = 1'b0;
        chk("over_valid", e, 0);
        chk("over_addr_hold", vid_addr, 6143);
        chk("over_busy", line_busy, 0);
`endif

        // frame_start together with line_start restarts from line 0
        run_line(1'b0, 1, 1'b1, -1);
        chk("fs_addr0", addrq[0], 0);
        chk("fs_line", line_errs(1'b0), 0);
        chk("fs_underrun", underrun, 0);

        // reset in the middle of a line
        line_start = 1'b1;
        pix_ce = 1'b1;
        tick();
        line_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 100; c++) begin
            tick();
            if (pix_valid) cnt++;
        end
        chk("mid_reached", cnt, 100);
        chk("mid_addr_nonzero", (vid_addr != 13'd0), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", vid_addr, 0);
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_data", pix_data, 0);
        chk("mid_rst_busy", line_busy, 0);
        chk("mid_rst_underrun", underrun, 0);
        pix_ce = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        done_lines = 0;
        tick();
        run_line(1'b0, 1, 1'b0, -1);
        chk("post_rst_addr0", addrq[0], 0);
        chk("post_rst_line", line_errs(1'b0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vid_fetch.md
Name: vid_fetch

Overview:
- Display-side reader for the dual-port video RAM (6144 x 8, read port with 1-clk registered latency).
- Driven by the video timing generator's strobes. Issues read addresses on the RAM video port, prefetches one byte ahead, and serialises bytes into a pixel stream for the HDMI/VGA colour mapper.
- Supports 256x192 1bpp and 128x192 2bpp (horizontally doubled) graphics. Both modes consume 32 bytes per line.

Parameters:
- LINES, 192: active lines per frame.
- BYTES_PER_LINE, 32: bytes fetched per active line.
- BASE_ADDR, 0: RAM address of line 0, byte 0.
- ADDR_W, 13: RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable, one clk wide, at most every clk.
- frame_start  in  1  one-clk strobe; line counter := 0, underrun cleared.
- line_start  in  1  one-clk strobe; begin fetch/serialise of current line.
- mode  in  1  0 = 1bpp 256 wide, 1 = 2bpp 128 wide doubled; sampled at line_start.
- vid_addr  out  ADDR_W  read address to RAM video port (registered).
- vid_dout  in  8  RAM read data, valid 1 clk after vid_addr.
- pix_valid  out  1  pixel on pix_data is active display.
- pix_data  out  2  colour index; 1bpp mode outputs {1'b0, bit}.
- line_busy  out  1  high from accepted line_start until last pixel shifted.
- underrun  out  1  sticky; pixel demanded with no byte available.

Behaviour:
- Reset (async, reset_n low): vid_addr = BASE_ADDR, pix_valid = 0, pix_data = 0, line_busy = 0, underrun = 0, line counter = 0, state = IDLE. Reset mid-line abandons the line immediately.
- Address: vid_addr = BASE_ADDR + line*BYTES_PER_LINE + byte_idx. Line 191, byte 31 = 6143. No modular wrap.
- State machine:
  - IDLE: wait for line_start.
  - PRIME: issue byte 0. Next clk capture vid_dout into the shifter, then issue byte 1.
  - ACTIVE: shift on pix_ce.
  - IDLE again after the final pixel of byte 31.
- Line acceptance: line_start is accepted only in IDLE with line < LINES. It is ignored while line_busy=1, and ignored when line >= LINES (pix_valid stays 0, vid_addr holds).
- Line counter: increments at the end of each completed line. A frame_start coincident with line_start takes priority: counter = 0 and the line is fetched as line 0.
- Latency: the shifter is loaded 2 clk after an accepted line_start. The first pix_valid occurs on the first pix_ce at least 3 clk after line_start. Timing generator contract: line_start leads the first active pix_ce by >= 3 clk. pix_ce strobes before the shifter is loaded produce no output.
- Output timing: pix_valid and pix_data update on the clk of each consumed pix_ce and hold between strobes. pix_valid drops on the pix_ce following the last pixel.
- Prefetch: one-byte hold register with a valid flag.
  - Next-byte request issues the clk after the shifter loads; data lands in the hold register 2 clk later.
  - Shifter empty on pix_ce: load from the hold register in the same clk, clear hold-valid, request the next byte. No request after byte 31.
- Pixel order:
  - 1bpp: bit 7 first, one pixel per pix_ce, 8 pix_ce per byte.
  - 2bpp: bits[7:6] first, each pair held for 2 pix_ce, 8 pix_ce per byte.
  - Both modes: 256 pix_ce per line.
- Underrun: shifter empty, hold invalid and pix_ce high → underrun := 1, pix_data := 0, pix_valid := 0 for that pixel. Unreachable with a legal pix_ce rate; cleared only by frame_start or reset.
- mode changes mid-line take effect at the next accepted line_start only.

Optional Feature:
- Macro: VID_FETCH_LINE_DOUBLE_EN.
- Defined: the line counter advances every second completed line, so each RAM line is displayed twice (384 output lines; accepted line_starts continue until the counter reaches LINES). A frame_start also resets the parity bit.
- Undefined: the line counter advances after every completed line; 192 output lines.

Test Plan:
- Reset mid-line: reset_n low at pixel 100 → all outputs 0 and vid_addr = 0 asynchronously; the next line_start after release fetches from address 0.
- 1bpp, pix_ce every clk, RAM[0..31]=0x80: frame_start, line_start → first pix_valid 3 clk later; pix_data = 1,0,0,0,0,0,0,0 repeating 32 times; 256 valid pixels; underrun = 0.
- 2bpp, pix_ce every 2nd clk, RAM[32]=0xE4, line 1: pix_data = 3,3,2,2,1,1,0,0 with vid_addr first = 32.
- Last line: after 191 completed lines, line_start → vid_addr sequence 6112..6143. A further line_start → ignored, pix_valid stays 0, vid_addr holds.
- line_start while line_busy=1, and frame_start coincident with line_start mid-frame → the first is ignored with no restart; the second fetches from address 0 and clears underrun.
- VID_FETCH_LINE_DOUBLE_EN: two consecutive lines → identical vid_addr sequences 0..31 twice, then 32..63 on the third line.
